pwm_ult: RTL and testbench
==========================

Name: pwm_ult

Overview:
- Registered PWM generator built around an unsigned less-than compare.
- A free-running counter is compared against a duty value with the invert-B, carry-in-1 subtract scheme; the output is high while count < duty.
- Sits upstream of board LED/IO pins, and is fed by a host or a test driver through a valid/ready load port.
- Targets icestick LUT4/CARRY fabric; the compare maps onto one carry chain.

Parameters:
- WIDTH, 8: counter, duty and period width in bits.
- PERIOD_RESET, 255: value of the active period register after reset (maximum count).

Ports:
- CLK  input  1  system clock, rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- CE  input  1  count enable; when low, the counter and commits hold.
- DUTY_I  input  WIDTH  duty value offered on the load port.
- PERIOD_I  input  WIDTH  period (max count) value offered on the load port.
- LOAD_VALID  input  1  a DUTY_I/PERIOD_I pair is offered.
- LOAD_READY  output  1  block can accept a pair.
- CNT_O  output  WIDTH  current counter value (registered).
- PWM_O  output  1  registered, equals (CNT_O < active duty), unsigned.

Behaviour:
- Clock and reset:
  - One clock, CLK.
  - Reset is asynchronous and active-low on RESETN.
  - RESETN low forces: count=0, active duty=0, active period=PERIOD_RESET, shadow empty, PWM_O=0, LOAD_READY=1.
  - Reset asserted mid-period aborts immediately.
  - A pending shadow pair is discarded on reset.
- Counter:
  - On each CE=1 edge, count increments.
  - When count==active period ("wrap cycle"), the next count is 0.
  - Counting covers 0..period inclusive, so the PWM period is period+1 CE cycles.
  - Period 0: count stays 0 and every CE cycle is a wrap cycle.
- Compare:
  - PWM_O is registered from next_count < next_duty.
  - It is therefore always cycle-aligned with CNT_O: PWM_O == (CNT_O < active duty).
  - Compare is unsigned via WIDTH-bit A + ~B + 1; lt = NOT carry-out.
  - Duty 0: PWM_O is always 0.
  - Duty > period: PWM_O is always 1.
- Load handshake:
  - A transfer occurs on an edge where LOAD_VALID & LOAD_READY.
  - LOAD_READY is 1 whenever the shadow is empty; it is combinational from the shadow flag only, never from LOAD_VALID.
  - The accepted pair goes into the shadow, and LOAD_READY drops the next cycle.
  - The shadow commits to active duty/period on the next wrap cycle with CE=1; the shadow then empties and LOAD_READY returns to 1 the following cycle.
- Simultaneous events:
  - Transfer in a wrap cycle with CE=1: the pair commits directly into active registers at that edge. The shadow stays empty and LOAD_READY stays 1.
  - CE=0: no counting and no commit; transfers into an empty shadow are still accepted.
  - A new period smaller than the current count is harmless, because commits happen only at wrap.
- Latency:
  - The duty/period change is visible on PWM_O from the first count=0 cycle after the commit edge.

Optional Feature:
- Macro: PWM_ULT_WRAP_PULSE_EN.
- Defined:
  - Adds output port WRAP_O (1 bit).
  - WRAP_O is a registered one-cycle pulse, high in exactly the cycles where CNT_O has just wrapped to 0 (aligned with CNT_O).
  - WRAP_O resets to 0.
  - With CE=0 it stays 0 after its single cycle.
- Undefined: the port is absent and no wrap-pulse logic is generated.

Decomposition:
- Package pwm_ult_pkg:
  - WIDTH default constant.
  - PERIOD_RESET default constant.
  - Typedef for the shadow load record {duty, period}.
- Sub-module ult_cmp (parameter WIDTH):
  - Combinational unsigned less-than: inputs A, B; output LT.
  - Built as an invert-B plus carry-in-1 adder chain, with LT = NOT carry-out.
  - Instantiated once, on next_count/next_duty.
- All state lives in pwm_ult.

Test Plan:
- Reset, then CE=1, no loads, PERIOD_RESET=255 -> CNT_O runs 0..255 and wraps to 0; PWM_O stays 0 (duty 0); LOAD_READY=1.
- Load duty=3, period=7 in a non-wrap cycle -> LOAD_READY low until the next wrap. After the commit, CNT_O runs 0..7 repeating and PWM_O is 1,1,1,0,0,0,0,0 per period.
- Load duty=9, period=7 -> PWM_O constant 1. Then load duty=0, period=7 -> PWM_O constant 0 from the next count=0.
- Transfer exactly in the wrap cycle (CNT_O==period, CE=1) with duty=2, period=3 -> new values take effect at the immediately following count=0; LOAD_READY never drops.
- Hold CE=0 for 5 cycles mid-period with a pending shadow -> CNT_O and PWM_O frozen, no commit. Assert RESETN=0 asynchronously mid-period -> all outputs go to reset values before the next CLK edge and the shadow is discarded.
- With PWM_ULT_WRAP_PULSE_EN and period=0 -> CNT_O stuck at 0 and WRAP_O=1 every CE cycle. With period=4 -> one WRAP_O pulse every 5 CE cycles.

Source files
------------

// File: rtl/pwm_ult_pkg.sv
// ============================================================================
// Module   : pwm_ult_pkg
// Purpose  : Shared defaults and the shadow load record for the pwm_ult PWM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_ult_pkg;

   localparam int unsigned c_WIDTH        = 8;
   localparam int unsigned c_PERIOD_RESET = 255;

   // Record fields are sized for the widest supported WIDTH and cast down on use.
   localparam int unsigned c_REC_WIDTH    = 32;

   typedef struct packed {
      logic [c_REC_WIDTH-1:0] duty;
      logic [c_REC_WIDTH-1:0] period;
   } load_rec_t;

endpackage

`default_nettype wire

// File: rtl/ult_cmp.sv
// ============================================================================
// Module   : ult_cmp
// Purpose  : Unsigned A < B built as A + ~B + 1; LT is the inverted carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ult_cmp #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             LT
);

   logic [WIDTH:0] w_carry;

   assign w_carry[0] = 1'b1;

   // Only the carries are kept, so this maps onto a single carry chain.
   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      assign w_carry[i+1] = (A[i] & ~B[i]) | ((A[i] ^ ~B[i]) & w_carry[i]);
   end

   assign LT = ~w_carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/pwm_ult.sv
// ============================================================================
// Module   : pwm_ult
// Purpose  : Registered PWM generator with a shadowed valid/ready load port.
//            Optional macro PWM_ULT_WRAP_PULSE_EN adds the WRAP_O pulse output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_ult
   import pwm_ult_pkg::*;
#(
   parameter int unsigned WIDTH        = c_WIDTH,
   parameter int unsigned PERIOD_RESET = c_PERIOD_RESET
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             CE,
   input  logic [WIDTH-1:0] DUTY_I,
   input  logic [WIDTH-1:0] PERIOD_I,
   input  logic             LOAD_VALID,
   output logic             LOAD_READY,
   output logic [WIDTH-1:0] CNT_O,
   output logic             PWM_O
`ifdef PWM_ULT_WRAP_PULSE_EN
   ,
   output logic             WRAP_O
`endif
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic [WIDTH-1:0] period_q, period_d;
   load_rec_t        shadow_q, shadow_d;
   logic             shadow_vld_q, shadow_vld_d;
   logic             pwm_q;
   logic             w_wrap;
   logic             w_fire;
   logic             w_lt;

   assign w_wrap = (cnt_q == period_q);
   assign w_fire = LOAD_VALID & ~shadow_vld_q;

   always_comb begin
      cnt_d        = cnt_q;
      duty_d       = duty_q;
      period_d     = period_q;
      shadow_d     = shadow_q;
      shadow_vld_d = shadow_vld_q;
      if (CE && w_wrap) begin
         cnt_d = '0;
         if (shadow_vld_q) begin
            duty_d       = WIDTH'(shadow_q.duty);
            period_d     = WIDTH'(shadow_q.period);
            shadow_vld_d = 1'b0;
         end else if (w_fire) begin
            // A pair arriving exactly at the wrap bypasses the shadow.
            duty_d   = DUTY_I;
            period_d = PERIOD_I;
         end
      end else begin
         if (CE) begin
            cnt_d = cnt_q + WIDTH'(1);
         end
         if (w_fire) begin
            shadow_d.duty   = c_REC_WIDTH'(DUTY_I);
            shadow_d.period = c_REC_WIDTH'(PERIOD_I);
            shadow_vld_d    = 1'b1;
         end
      end
   end

   // Compare on next-state values so PWM_O stays aligned with CNT_O.
   ult_cmp #(.WIDTH(WIDTH)) u_cmp (
      .A  (cnt_d),
      .B  (duty_d),
      .LT (w_lt)
   );

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         cnt_q        <= '0;
         duty_q       <= '0;
         period_q     <= WIDTH'(PERIOD_RESET);
         shadow_q     <= '0;
         shadow_vld_q <= 1'b0;
         pwm_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         duty_q       <= duty_d;
         period_q     <= period_d;
         shadow_q     <= shadow_d;
         shadow_vld_q <= shadow_vld_d;
         pwm_q        <= w_lt;
      end
   end

   assign LOAD_READY = ~shadow_vld_q;
   assign CNT_O      = cnt_q;
   assign PWM_O      = pwm_q;

`ifdef PWM_ULT_WRAP_PULSE_EN
   logic wrap_q;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= CE & w_wrap;
      end
   end

   assign WRAP_O = wrap_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwm_ult.sv
// ============================================================================
// Module   : tb_pwm_ult
// Purpose  : Self-checking bench for pwm_ult (scoreboard plus pattern checks).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_ult;

   localparam int unsigned W = 8;
`ifdef PWM_ULT_WRAP_PULSE_EN
   localparam bit HAS_WRAP = 1'b1;
`else
   localparam bit HAS_WRAP = 1'b0;
`endif

   logic         CLK;
   logic         RESETN;
   logic         CE;
   logic [W-1:0] DUTY_I;
   logic [W-1:0] PERIOD_I;
   logic         LOAD_VALID;
   logic         LOAD_READY;
   logic [W-1:0] CNT_O;
   logic         PWM_O;
   logic         wrap_obs;

   pwm_ult #(.WIDTH(W), .PERIOD_RESET(255)) dut (
      .CLK        (CLK),
      .RESETN     (RESETN),
      .CE         (CE),
      .DUTY_I     (DUTY_I),
      .PERIOD_I   (PERIOD_I),
      .LOAD_VALID (LOAD_VALID),
      .LOAD_READY (LOAD_READY),
      .CNT_O      (CNT_O),
      .PWM_O      (PWM_O)
`ifdef PWM_ULT_WRAP_PULSE_EN
      ,
      .WRAP_O     (wrap_obs)
`endif
   );

`ifndef PWM_ULT_WRAP_PULSE_EN
   assign wrap_obs = 1'b0;
`endif

   wire [W+2:0] w_obs = {CNT_O, PWM_O, LOAD_READY, wrap_obs};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference state, written directly from the behavioural description.
   logic [W-1:0] m_cnt, m_duty, m_per, m_sd, m_sp;
   logic         m_vld, m_wrap;
   logic [W+2:0] sb_q[$];

   task automatic reset_model();
      m_cnt = '0; m_duty = '0; m_per = 8'd255; m_vld = 1'b0; m_wrap = 1'b0;
      m_sd = '0; m_sp = '0;
   endtask

   // Predict the next cycle from the driven inputs, push it, then advance.
   task automatic sb_tick();
      logic fire;
      fire = LOAD_VALID && !m_vld;
      if (!RESETN) begin
         reset_model();
      end else if (CE && (m_cnt == m_per)) begin
         m_cnt  = '0;
         m_wrap = 1'b1;
         if (m_vld) begin
            m_duty = m_sd; m_per = m_sp; m_vld = 1'b0;
         end else if (fire) begin
            m_duty = DUTY_I; m_per = PERIOD_I;
         end
      end else begin
         if (CE) m_cnt = m_cnt + 8'd1;
         m_wrap = 1'b0;
         if (fire) begin
            m_sd = DUTY_I; m_sp = PERIOD_I; m_vld = 1'b1;
         end
      end
      sb_q.push_back({m_cnt, (m_cnt < m_duty), !m_vld, (HAS_WRAP ? m_wrap : 1'b0)});
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      logic [W+2:0] e;
      RESETN = 1'b0; CE = 1'b0; LOAD_VALID = 1'b0; DUTY_I = '0; PERIOD_I = '0;
      sb_tick();
      e = sb_q.pop_front(); n_chk++;
      if (w_obs !== e) begin n_fail++; $display("FAIL sb_reset: got %h expected %h", w_obs, e); end
      n_chk++;
      if ({CNT_O, PWM_O, LOAD_READY, wrap_obs} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_outputs: cnt=%0d pwm=%b rdy=%b wrap=%b required 0 0 1 0",
                  CNT_O, PWM_O, LOAD_READY, wrap_obs);
      end
      RESETN = 1'b1;
   endtask

   task automatic test_free_run();
      logic [W+2:0] e;
      CE = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         sb_tick();
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_free_run: got %h expected %h", w_obs, e); end
         n_chk++;
         if (CNT_O !== W'(i) || PWM_O !== 1'b0 || LOAD_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL free_run: cnt=%0d pwm=%b rdy=%b required %0d 0 1", CNT_O, PWM_O, LOAD_READY, W'(i));
         end
      end
   endtask

   task automatic test_load();
      logic [W+2:0] e;
      int guard;
      LOAD_VALID = 1'b1; DUTY_I = 8'd3; PERIOD_I = 8'd7;
      sb_tick();
      LOAD_VALID = 1'b0;
      e = sb_q.pop_front(); n_chk++;
      if (w_obs !== e) begin n_fail++; $display("FAIL sb_load: got %h expected %h", w_obs, e); end
      n_chk++;
      if (LOAD_READY !== 1'b0) begin n_fail++; $display("FAIL load_ready_drop: got %b required 0", LOAD_READY); end
      guard = 0;
      while (CNT_O !== 8'd0 && guard < 300) begin
         sb_tick();
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_load_wait: got %h expected %h", w_obs, e); end
         guard++;
      end
      n_chk++;
      if (CNT_O !== 8'd0 || LOAD_READY !== 1'b1) begin
         n_fail++; $display("FAIL load_commit: cnt=%0d rdy=%b required 0 1", CNT_O, LOAD_READY);
      end
      for (int k = 0; k < 16; k++) begin
         n_chk++;
         if (CNT_O !== W'(k % 8) || PWM_O !== ((k % 8) < 3)) begin
            n_fail++;
            $display("FAIL load_pattern: cnt=%0d pwm=%b required %0d %b", CNT_O, PWM_O, k % 8, ((k % 8) < 3));
         end
         sb_tick();
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_load_pattern: got %h expected %h", w_obs, e); end
      end
   endtask

   task automatic test_duty_edges();
      logic [W+2:0] e;
      logic [W-1:0] duties [2] = '{8'd9, 8'd0};
      logic         levels [2] = '{1'b1, 1'b0};
      int guard;
      for (int d = 0; d < 2; d++) begin
         LOAD_VALID = 1'b1; DUTY_I = duties[d]; PERIOD_I = 8'd7;
         sb_tick();
         LOAD_VALID = 1'b0;
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_duty_load: got %h expected %h", w_obs, e); end
         guard = 0;
         while (CNT_O !== 8'd0 && guard < 300) begin
            sb_tick();
            e = sb_q.pop_front(); n_chk++;
            if (w_obs !== e) begin n_fail++; $display("FAIL sb_duty_wait: got %h expected %h", w_obs, e); end
            guard++;
         end
         for (int k = 0; k < 16; k++) begin
            n_chk++;
            if (PWM_O !== levels[d] || CNT_O !== W'(k % 8)) begin
               n_fail++;
               $display("FAIL duty_edge: duty=%0d cnt=%0d pwm=%b required cnt %0d pwm %b",
                        duties[d], CNT_O, PWM_O, k % 8, levels[d]);
            end
            sb_tick();
            e = sb_q.pop_front(); n_chk++;
            if (w_obs !== e) begin n_fail++; $display("FAIL sb_duty_edge: got %h expected %h", w_obs, e); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W+2:0] e;
      int guard = 0;
      while (CNT_O !== 8'd7 && guard < 20) begin
         sb_tick();
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_wrap_seek: got %h expected %h", w_obs, e); end
         guard++;
      end
      n_chk++;
      if (CNT_O !== 8'd7 || LOAD_READY !== 1'b1) begin
         n_fail++; $display("FAIL wrap_seek: cnt=%0d rdy=%b required 7 1", CNT_O, LOAD_READY);
      end
      LOAD_VALID = 1'b1; DUTY_I = 8'd2; PERIOD_I = 8'd3;
      sb_tick();
      LOAD_VALID = 1'b0;
      e = sb_q.pop_front(); n_chk++;
      if (w_obs !== e) begin n_fail++; $display("FAIL sb_wrap_load: got %h expected %h", w_obs, e); end
      for (int k = 0; k < 8; k++) begin
         n_chk++;
         if (CNT_O !== W'(k % 4) || PWM_O !== ((k % 4) < 2) || LOAD_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_load: cnt=%0d pwm=%b rdy=%b required %0d %b 1",
                     CNT_O, PWM_O, LOAD_READY, k % 4, ((k % 4) < 2));
         end
         sb_tick();
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_wrap_run: got %h expected %h", w_obs, e); end
      end
   endtask

   task automatic test_ce_hold_reset();
      logic [W+2:0] e;
      // Count 0 -> 1, then load a pending pair at count 1.
      sb_tick();
      e = sb_q.pop_front(); n_chk++;
      if (w_obs !== e) begin n_fail++; $display("FAIL sb_hold_pre: got %h expected %h", w_obs, e); end
      LOAD_VALID = 1'b1; DUTY_I = 8'd1; PERIOD_I = 8'd5;
      for (int k = 0; k < 2; k++) begin
         sb_tick();
         LOAD_VALID = 1'b0;
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_hold_load: got %h expected %h", w_obs, e); end
      end
      CE = 1'b0;
      for (int k = 0; k < 5; k++) begin
         sb_tick();
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_hold: got %h expected %h", w_obs, e); end
         n_chk++;
         if (CNT_O !== 8'd3 || PWM_O !== 1'b0 || LOAD_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL ce_hold: cnt=%0d pwm=%b rdy=%b required 3 0 0", CNT_O, PWM_O, LOAD_READY);
         end
      end
      #2;
      RESETN = 1'b0;
      #1;
      n_chk++;
      if ({CNT_O, PWM_O, LOAD_READY, wrap_obs} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset: cnt=%0d pwm=%b rdy=%b wrap=%b required 0 0 1 0",
                  CNT_O, PWM_O, LOAD_READY, wrap_obs);
      end
      reset_model();
      sb_q.delete();
      @(posedge CLK);
      #1;
      RESETN = 1'b1; CE = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         sb_tick();
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_post_reset: got %h expected %h", w_obs, e); end
         n_chk++;
         if (CNT_O !== W'(i) || PWM_O !== 1'b0) begin
            n_fail++;
            $display("FAIL shadow_discard: cnt=%0d pwm=%b required %0d 0", CNT_O, PWM_O, W'(i));
         end
      end
   endtask

`ifdef PWM_ULT_WRAP_PULSE_EN
   task automatic test_wrap_pulse();
      logic [W+2:0] e;
      int guard = 0;
      LOAD_VALID = 1'b1; DUTY_I = 8'd0; PERIOD_I = 8'd0;
      sb_tick();
      LOAD_VALID = 1'b0;
      e = sb_q.pop_front(); n_chk++;
      if (w_obs !== e) begin n_fail++; $display("FAIL sb_p0_load: got %h expected %h", w_obs, e); end
      while (CNT_O !== 8'd0 && guard < 300) begin
         sb_tick();
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_p0_wait: got %h expected %h", w_obs, e); end
         guard++;
      end
      for (int k = 0; k < 8; k++) begin
         n_chk++;
         if (CNT_O !== 8'd0 || wrap_obs !== 1'b1) begin
            n_fail++; $display("FAIL period0_wrap: cnt=%0d wrap=%b required 0 1", CNT_O, wrap_obs);
         end
         sb_tick();
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_p0: got %h expected %h", w_obs, e); end
      end
      LOAD_VALID = 1'b1; DUTY_I = 8'd0; PERIOD_I = 8'd4;
      sb_tick();
      LOAD_VALID = 1'b0;
      e = sb_q.pop_front(); n_chk++;
      if (w_obs !== e) begin n_fail++; $display("FAIL sb_p4_load: got %h expected %h", w_obs, e); end
      for (int k = 0; k < 10; k++) begin
         n_chk++;
         if (CNT_O !== W'(k % 5) || wrap_obs !== ((k % 5) == 0)) begin
            n_fail++;
            $display("FAIL period4_wrap: cnt=%0d wrap=%b required %0d %b", CNT_O, wrap_obs, k % 5, ((k % 5) == 0));
         end
         sb_tick();
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_p4: got %h expected %h", w_obs, e); end
      end
      CE = 1'b0;
      for (int k = 0; k < 2; k++) begin
         sb_tick();
         e = sb_q.pop_front(); n_chk++;
         if (w_obs !== e) begin n_fail++; $display("FAIL sb_wrap_ce0: got %h expected %h", w_obs, e); end
         n_chk++;
         if (CNT_O !== 8'd0 || wrap_obs !== 1'b0) begin
            n_fail++; $display("FAIL wrap_ce0: cnt=%0d wrap=%b required 0 0", CNT_O, wrap_obs);
         end
      end
      CE = 1'b1;
   endtask
`endif

   initial begin
      reset_model();
      test_reset();
      test_free_run();
      test_load();
      test_duty_edges();
      test_back_to_back();
      test_ce_hold_reset();
`ifdef PWM_ULT_WRAP_PULSE_EN
      test_wrap_pulse();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
